// File: rtl/s_array_ctrl.sv
// s_array_ctrl: load/stream/drain sequencer for a 4x4 weight-stationary array.
// Optional S_ARRAY_CTRL_BIAS_EN adds a per-job bias injected via psum_in.
module s_array_ctrl #(
  parameter int bit_width = 8,
  parameter int cnt_w     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     keep_w,
  input  logic [cnt_w-1:0]         num_vec,
  output logic                     busy,
  output logic                     done,
  input  logic                     w_valid,
  output logic                     w_ready,
  input  logic [4*bit_width-1:0]   w_data,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [4*bit_width-1:0]   a_data,
`ifdef S_ARRAY_CTRL_BIAS_EN
  input  logic [12*bit_width-1:0]  bias_data,
`endif
  output logic                     r_valid,
  output logic [12*bit_width-1:0]  r_data,
  output logic                     arr_ld_w_en,
  output logic [1:0]               arr_ld_w_id,
  output logic [4*bit_width-1:0]   arr_w_in,
  output logic [4*bit_width-1:0]   arr_a_in,
  output logic [12*bit_width-1:0]  arr_psum_in,
  input  logic [12*bit_width-1:0]  arr_psum_out
);

  localparam int pw = 3 * bit_width;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD_W = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;
  localparam logic [1:0] DRAIN  = 2'd3;

  localparam logic [cnt_w-1:0] one = 1;

  logic [1:0]         state;
  logic [1:0]         rcnt;
  logic [cnt_w-1:0]   vcnt;
  logic [cnt_w-1:0]   nv;
  logic [8:0]         vp;
  logic [12*bit_width-1:0] aligned;
  logic               w_acc;
  logic               a_acc;
  logic               last_a;
  logic               empty;

`ifdef S_ARRAY_CTRL_BIAS_EN
  logic [12*bit_width-1:0] bias_q;
`endif

  assign busy    = (state != IDLE);
  assign w_ready = (state == LOAD_W);
  assign a_ready = (state == STREAM) && (vcnt != nv);
  assign w_acc   = w_valid && w_ready;
  assign a_acc   = a_valid && a_ready;
  assign last_a  = a_acc && ((vcnt + one) == nv);
  assign empty   = ~|vp;
  assign r_valid = vp[8];

  // Job sequencing and completion pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rcnt  <= '0;
      vcnt  <= '0;
      nv    <= '0;
      done  <= 1'b0;
`ifdef S_ARRAY_CTRL_BIAS_EN
      bias_q <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            nv    <= num_vec;
            vcnt  <= '0;
            rcnt  <= '0;
            state <= keep_w ? STREAM : LOAD_W;
`ifdef S_ARRAY_CTRL_BIAS_EN
            bias_q <= bias_data;
`endif
          end
        end
        LOAD_W: begin
          if (w_acc) begin
            rcnt <= rcnt + 2'd1;
            if (rcnt == 2'd3) state <= STREAM;
          end
        end
        STREAM: begin
          if (a_acc) vcnt <= vcnt + one;
          if ((vcnt == nv) || last_a) state <= DRAIN;
        end
        DRAIN: begin
          if (empty) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered weight-row load port
  always_ff @(posedge clk) begin
    if (rst) begin
      arr_ld_w_en <= 1'b0;
      arr_ld_w_id <= '0;
      arr_w_in    <= '0;
    end else begin
      arr_ld_w_en <= w_acc;
      if (w_acc) begin
        arr_ld_w_id <= rcnt;
        arr_w_in    <= w_data;
      end
    end
  end

  // Occupancy pipeline: bit i marks a vector accepted i+1 cycles ago
  always_ff @(posedge clk) begin
    if (rst) vp <= '0;
    else     vp <= {vp[7:0], a_acc};
  end

  // Input skew: lane k is delayed k+1 cycles, bubbles carry zero
  for (genvar k = 0; k < 4; k++) begin : g_skew
    logic [bit_width-1:0] sr [0:k];
    // Shift chain for one activation lane
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j <= k; j++) sr[j] <= '0;
      end else begin
        sr[0] <= a_acc ? a_data[k*bit_width +: bit_width] : '0;
        for (int j = 1; j <= k; j++) sr[j] <= sr[j-1];
      end
    end
    assign arr_a_in[k*bit_width +: bit_width] = sr[k];
  end

  // Output deskew: column c is delayed 3-c cycles to line up all lanes
  for (genvar c = 0; c < 4; c++) begin : g_dsk
    if (c == 3) begin : g_pass
      assign aligned[c*pw +: pw] = arr_psum_out[c*pw +: pw];
    end else begin : g_dly
      logic [pw-1:0] dr [0:2-c];
      // Delay chain for one partial-sum column
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int j = 0; j <= 2-c; j++) dr[j] <= '0;
        end else begin
          dr[0] <= arr_psum_out[c*pw +: pw];
          for (int j = 1; j <= 2-c; j++) dr[j] <= dr[j-1];
        end
      end
      assign aligned[c*pw +: pw] = dr[2-c];
    end
  end

  // Result register, zero outside valid cycles
  always_ff @(posedge clk) begin
    if (rst)        r_data <= '0;
    else if (vp[7]) r_data <= aligned;
    else            r_data <= '0;
  end

`ifdef S_ARRAY_CTRL_BIAS_EN
  for (genvar c = 0; c < 4; c++) begin : g_bias
    assign arr_psum_in[c*pw +: pw] = vp[c] ? bias_q[c*pw +: pw] : '0;
  end
`else
  assign arr_psum_in = '0;
`endif

endmodule

// File: tb/tb_s_array_ctrl.sv
// tb_s_array_ctrl: directed bench for s_array_ctrl with a behavioural
// 4x4 weight-stationary array attached to the array-side ports.
module tb_s_array_ctrl;

  localparam int BW = 8;
  localparam int PW = 24;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        keep_w = 1'b0;
  logic [15:0] num_vec = '0;
  logic        busy, done;
  logic        w_valid = 1'b0;
  logic        w_ready;
  logic [31:0] w_data = '0;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [31:0] a_data = '0;
  logic        r_valid;
  logic [95:0] r_data;
  logic        arr_ld_w_en;
  logic [1:0]  arr_ld_w_id;
  logic [31:0] arr_w_in;
  logic [31:0] arr_a_in;
  logic [95:0] arr_psum_in;
  logic [95:0] arr_psum_out;

  s_array_ctrl #(.bit_width(8), .cnt_w(16)) dut (
    .clk(clk), .rst(rst), .start(start), .keep_w(keep_w),
    .num_vec(num_vec), .busy(busy), .done(done),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
`ifdef S_ARRAY_CTRL_BIAS_EN
    .bias_data(96'd0),
`endif
    .r_valid(r_valid), .r_data(r_data),
    .arr_ld_w_en(arr_ld_w_en), .arr_ld_w_id(arr_ld_w_id),
    .arr_w_in(arr_w_in), .arr_a_in(arr_a_in),
    .arr_psum_in(arr_psum_in), .arr_psum_out(arr_psum_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural array: weights stay resident, a and psum registered per MAC
  logic [BW-1:0] wt [4][4];
  logic [BW-1:0] ar [4][4];
  logic [PW-1:0] pr [4][4];

  initial begin
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        wt[r][c] = '0; ar[r][c] = '0; pr[r][c] = '0;
      end
  end

  function automatic logic [BW-1:0] ain(int r, int c);
    if (c == 0) return arr_a_in[r*BW +: BW];
    return ar[r][c-1];
  endfunction

  function automatic logic [PW-1:0] pin(int r, int c);
    if (r == 0) return arr_psum_in[c*PW +: PW];
    return pr[r-1][c];
  endfunction

  always @(posedge clk) begin
    if (arr_ld_w_en)
      for (int c = 0; c < 4; c++) wt[arr_ld_w_id][c] <= arr_w_in[c*BW +: BW];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ar[r][c] <= ain(r, c);
        pr[r][c] <= pin(r, c) + PW'(wt[r][c]) * PW'(ain(r, c));
      end
  end

  assign arr_psum_out = {pr[3][3], pr[3][2], pr[3][1], pr[3][0]};

  // event log
  int          acc_q[$];
  int          wacc_q[$];
  int          res_cyc[$];
  logic [95:0] res_dat[$];
  int          ld_cyc[$];
  int          ld_id[$];
  logic [31:0] ld_w[$];
  int          done_q[$];
  int          start_q[$];
  int          busy_n;
  logic [95:0] psum_or;

  always @(negedge clk) begin
    if (!rst) begin
      if (a_valid && a_ready) acc_q.push_back(cyc);
      if (w_valid && w_ready) wacc_q.push_back(cyc);
      if (r_valid) begin
        res_cyc.push_back(cyc);
        res_dat.push_back(r_data);
      end
      if (arr_ld_w_en) begin
        ld_cyc.push_back(cyc);
        ld_id.push_back(int'(arr_ld_w_id));
        ld_w.push_back(arr_w_in);
      end
      if (done) done_q.push_back(cyc);
      if (start && !busy) start_q.push_back(cyc);
      if (busy) busy_n++;
      psum_or = psum_or | arr_psum_in;
    end
  end

  int nerr = 0;
  int nchk = 0;

  task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [95:0] rep(int v);
    return {4{PW'(v)}};
  endfunction

  task automatic clr();
    acc_q.delete(); wacc_q.delete(); res_cyc.delete(); res_dat.delete();
    ld_cyc.delete(); ld_id.delete(); ld_w.delete(); done_q.delete();
    start_q.delete(); busy_n = 0; psum_or = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(logic kw, int nv);
    start = 1'b1; keep_w = kw; num_vec = 16'(nv);
    tick();
    start = 1'b0;
  endtask

  task automatic send_w(logic [31:0] d);
    int n = 0;
    w_valid = 1'b1; w_data = d;
    @(negedge clk);
    while (!w_ready && n < 50) begin n++; @(negedge clk); end
    if (n >= 50) check("w_ready_timeout", 0, 1);
    tick();
    w_valid = 1'b0;
  endtask

  task automatic send_a(logic [31:0] d);
    int n = 0;
    a_valid = 1'b1; a_data = d;
    @(negedge clk);
    while (!a_ready && n < 50) begin n++; @(negedge clk); end
    if (n >= 50) check("a_ready_timeout", 0, 1);
    tick();
    a_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!done && n < 100) begin n++; @(negedge clk); end
    if (n >= 100) check("done_timeout", 0, 1);
    tick();
  endtask

  task automatic chk_res(string tag, int i, logic [95:0] exp);
    if (res_cyc.size() > i && acc_q.size() > i) begin
      check({tag, "_lat"}, 128'(res_cyc[i] - acc_q[i]), 128'(9));
      check({tag, "_data"}, 128'(res_dat[i]), 128'(exp));
    end else begin
      check({tag, "_missing"}, 0, 1);
    end
  endtask

  int t2;

  initial begin
    clr();
    repeat (3) tick();
    check("rst_busy", 128'(busy), 0);
    check("rst_done", 128'(done), 0);
    check("rst_wready", 128'(w_ready), 0);
    check("rst_aready", 128'(a_ready), 0);
    check("rst_rvalid", 128'(r_valid), 0);
    check("rst_rdata", 128'(r_data), 0);
    check("rst_ld", 128'({arr_ld_w_en, arr_ld_w_id, arr_w_in}), 0);
    check("rst_ain", 128'(arr_a_in), 0);
    rst = 1'b0;
    tick();

    // identity weights, single vector
    clr();
    go(1'b0, 1);
    for (int r = 0; r < 4; r++) send_w(32'h1 << (8*r));
    check("wready_after_load", 128'(w_ready), 0);
    send_a(32'h08070605);
    wait_done();
    check("ld_count", 128'(ld_cyc.size()), 4);
    for (int i = 0; i < 4; i++) begin
      if (ld_cyc.size() > i && wacc_q.size() > i) begin
        check("ld_id", 128'(ld_id[i]), 128'(i));
        check("ld_lat", 128'(ld_cyc[i] - wacc_q[i]), 1);
        check("ld_w", 128'(ld_w[i]), 128'(32'h1 << (8*i)));
      end
    end
    check("j1_nres", 128'(res_cyc.size()), 1);
    chk_res("j1", 0, {24'd8, 24'd7, 24'd6, 24'd5});
    if (done_q.size() == 1 && res_cyc.size() == 1)
      check("j1_done_cyc", 128'(done_q[0] - res_cyc[0]), 2);
    else
      check("j1_ndone", 128'(done_q.size()), 1);
    check("j1_busy_end", 128'(busy), 0);

    // all-ones weights, back-to-back vectors
    clr();
    go(1'b0, 4);
    for (int r = 0; r < 4; r++) send_w(32'h01010101);
    send_a(32'h01010101);
    send_a(32'h02020202);
    send_a(32'h00000003);
    send_a(32'hffffffff);
    wait_done();
    check("j2_nres", 128'(res_cyc.size()), 4);
    chk_res("j2_v0", 0, rep(4));
    chk_res("j2_v1", 1, rep(8));
    chk_res("j2_v2", 2, rep(3));
    chk_res("j2_v3", 3, rep(1020));
    if (res_cyc.size() == 4)
      check("j2_b2b", 128'(res_cyc[3] - res_cyc[0]), 3);
    check("j2_psum_in", 128'(psum_or), 0);

    // resident weights, gaps between vectors
    clr();
    go(1'b1, 3);
    send_a(32'h04030201); tick();
    send_a(32'h281e140a); tick();
    send_a(32'h01000007); tick();
    wait_done();
    check("j3_no_load", 128'(ld_cyc.size() + wacc_q.size()), 0);
    check("j3_nres", 128'(res_cyc.size()), 3);
    chk_res("j3_v0", 0, rep(10));
    chk_res("j3_v1", 1, rep(100));
    chk_res("j3_v2", 2, rep(8));
    if (acc_q.size() == 3)
      check("j3_gap", 128'(acc_q[1] - acc_q[0]), 2);

    // reset mid-job
    clr();
    go(1'b1, 4);
    send_a(32'h01010101);
    send_a(32'h02020202);
    t2 = cyc;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_busy", 128'(busy), 0);
    check("mrst_aready", 128'(a_ready), 0);
    check("mrst_rvalid", 128'(r_valid), 0);
    check("mrst_ain", 128'(arr_a_in), 0);
    check("mrst_rdata", 128'(r_data), 0);
    repeat (15) tick();
    check("mrst_no_res", 128'(res_cyc.size()), 0);
    check("mrst_no_done", 128'(done_q.size()), 0);
    clr();
    go(1'b1, 1);
    send_a(32'h01010101);
    wait_done();
    check("post_rst_nres", 128'(res_cyc.size()), 1);
    chk_res("post_rst", 0, rep(4));

    // empty job
    clr();
    go(1'b1, 0);
    wait_done();
    check("nv0_busy", 128'(busy_n), 2);
    check("nv0_nres", 128'(res_cyc.size()), 0);
    if (done_q.size() == 1 && start_q.size() == 1)
      check("nv0_done_cyc", 128'(done_q[0] - start_q[0]), 3);
    else
      check("nv0_ndone", 128'(done_q.size() + start_q.size()), 2);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/s_array_ctrl.md
Name: s_array_ctrl

Overview:
Sequencer for the 4x4 weight-stationary systolic array. It loads the four weight rows through the array's row-select load port, then streams activation vectors into the array with per-row input skew. It deskews the four column partial-sum outputs into one aligned result vector per input vector. It sits between the operand buffers (valid/ready streams) and the array instance.

Parameters:
- bit_width, 8, operand width; psum/result lane width is 3*bit_width
- cnt_w, 16, width of the vector-count input and internal counters

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse to begin a job; ignored while busy=1
- keep_w  in  1  sampled with start; 1 = skip weight load and reuse the resident weights
- num_vec  in  cnt_w  number of activation vectors in the job, sampled with start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the job completes
- w_valid  in  1  weight-row stream valid
- w_ready  out  1  weight-row stream ready
- w_data  in  4*bit_width  one weight row; lane c (bits c*bit_width +: bit_width, c=0..3) goes to column c+1
- a_valid  in  1  activation stream valid
- a_ready  out  1  activation stream ready
- a_data  in  4*bit_width  one activation vector; lane k goes to array row k+1
- r_valid  out  1  result valid, one-cycle pulse per vector; no backpressure
- r_data  out  12*bit_width  result; lane c (3*bit_width bits) holds column c+1
- arr_ld_w_en  out  1  to the array weight-load enable
- arr_ld_w_id  out  2  to the array weight-load row select
- arr_w_in  out  4*bit_width  to the array w_in_1..4 (lane c to column c+1)
- arr_a_in  out  4*bit_width  to the array a_in_1..4
- arr_psum_in  out  12*bit_width  to the array psum_in_1..4
- arr_psum_out  in  12*bit_width  from the array psum_out_1..4

Behaviour:
- Reset value of every output is 0. Reset returns the FSM to IDLE, clears all counters, skew and deskew registers and the valid pipeline, and squashes in-flight results. A reset mid-job gives no done and no further r_valid.
- States:
  - IDLE -> LOAD_W on start with keep_w=0.
  - IDLE -> STREAM on start with keep_w=1.
  - LOAD_W -> STREAM after 4 accepted rows.
  - STREAM -> DRAIN after num_vec vectors have been accepted.
  - DRAIN -> IDLE when the valid pipeline is empty; done pulses on that transition.
- num_vec=0: STREAM exits immediately and DRAIN completes after one cycle.
- LOAD_W:
  - w_ready=1. Row counter runs 0..3.
  - A row accepted at cycle t drives arr_ld_w_en=1, arr_ld_w_id=row and arr_w_in=w_data at cycle t+1 (registered).
  - arr_ld_w_en=0 in every other cycle.
- STREAM:
  - a_ready=1 until num_vec vectors are accepted; no other stall source. Gaps in a_valid are allowed.
  - For a vector accepted at cycle t, lane k appears on a_in_{k+1} at cycle t+1+k (skew register depth k+1). Bubble cycles drive 0.
  - arr_psum_in is 0.
- Array timing: each MAC registers a_out and psum_out. psum_out_{c+1} for that vector is valid at t+5+c.
  - Column c is delayed by 3-c cycles, so all lanes align at t+8.
  - r_data is registered, so r_valid=1 at exactly t+9.
  - A 9-deep valid shift register tracks occupancy.
- Result ordering equals acceptance order. Back-to-back vectors give back-to-back results.
- Arithmetic: no saturation or truncation inside the controller; the 3*bit_width lanes pass through unchanged.

Optional Feature:
- Macro: S_ARRAY_CTRL_BIAS_EN.
- Defined: adds input bias_data (12*bit_width), sampled with start. During STREAM, for every valid vector, arr_psum_in lane c = bias lane c, timed to reach column c+1 at t+1+c; bubble cycles drive 0. Each result lane equals dot product plus bias.
- Undefined: port absent and arr_psum_in tied to 0.

Test Plan:
- Weight load: start, keep_w=0, rows {1,2,3,4} x4 -> arr_ld_w_id 0,1,2,3 on the four cycles after each accept with arr_ld_w_en=1; w_ready=0 afterwards.
- Single vector: identity weights, a=(5,6,7,8), num_vec=1 -> r_valid exactly 9 cycles after accept, r_data lanes (5,6,7,8); done one cycle after pipeline empty.
- Streaming: weights all 1, 4 back-to-back vectors (1,1,1,1),(2,2,2,2),(3,0,0,0),(255,255,255,255) -> 4 consecutive r_valid with lanes 4, 8, 3, 1020.
- Bubbles plus keep_w: second job with keep_w=1, a_valid toggling 1/0, num_vec=3 -> no LOAD_W, results spaced as inputs, each at accept+9.
- Reset mid-job: assert rst 3 cycles after the 2nd vector accept -> all outputs 0 next cycle, no r_valid or done follow; a new start then completes normally.
- num_vec=0 with keep_w=1 -> busy for 2 cycles then done, no r_valid.
